traffic_light_controller: RTL and testbench

Sequencing FSM for the intersection: it drives the interval `timer` with a duration code and a one-cycle `start_timer` pulse, then consumes the timer's `expired` flag to advance through the main/side/walk phases. It sits directly upstream of `timer` and downstream of the sensor/button synchronisers. It produces registered lamp outputs for the main street, the side street and the pedestrian signal.

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/request_latch.sv | 25 ++
 rtl/traffic_light_controller.sv | 139 +++++++++++++
 tb/tb_traffic_light_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: phase
// enumeration, one-hot lamp encodings and default phase durations.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MG1,
        ST_MG2,
        ST_MY,
        ST_WALK,
        ST_SG,
        ST_SGX,
        ST_SY
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int T_BASE_DEF = 6;
    localparam int T_EXT_DEF  = 3;
    localparam int T_YEL_DEF  = 2;
    localparam int T_WALK_DEF = 3;

    // Durations travel to the timer as a 4-bit code.
    function automatic logic [3:0] dur_code(input int d);
        return 4'(d);
    endfunction

endpackage

// File: rtl/request_latch.sv
// Sticky request flag: set and clear in the same cycle leaves it set, so a
// request arriving while it is being consumed is kept for the next round.
module request_latch (
    input  logic clock,
    input  logic reset_n,
    input  logic i_set,
    input  logic i_clr,
    output logic o_flag
);

    logic r_flag;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_flag <= 1'b0;
        end else if (i_set) begin
            r_flag <= 1'b1;
        end else if (i_clr) begin
            r_flag <= 1'b0;
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/traffic_light_controller.sv
// Phase sequencer for the intersection: loads the external interval timer on
// every phase entry and advances on its expiry, with registered lamp outputs.
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int T_BASE = T_BASE_DEF,
    parameter int T_EXT  = T_EXT_DEF,
    parameter int T_YEL  = T_YEL_DEF,
    parameter int T_WALK = T_WALK_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       expired,
    input  logic       sensor,
    input  logic       walk_request,
    output logic [3:0] value,
    output logic       start_timer,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_lamp
);

    if (T_BASE < 1 || T_EXT < 1 || T_YEL < 1 || T_WALK < 1) begin : g_bad_duration
        $fatal(1, "traffic_light_controller: phase durations must be non-zero");
    end

    state_t     r_state;
    state_t     w_next_state;
    logic       r_start;
    logic       r_start_d;
    logic       r_pend;
    logic [3:0] r_value;
    logic [2:0] r_main;
    logic [2:0] r_side;
    logic       r_walk_lamp;

    logic       w_qual;
    logic       w_load;
    logic       w_walk_latched;
    logic       w_enter_walk;
    logic [3:0] w_value;
    logic [2:0] w_main;
    logic [2:0] w_side;
    logic       w_walk;

    // The timer's expired flag may still be high from the previous interval
    // for up to two cycles after a load, so those cycles are ignored.
    assign w_qual = expired & ~r_start & ~r_start_d & ~r_pend;

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (w_qual) begin
            case (r_state)
                ST_MG1:  w_next_state = sensor ? ST_MY : ST_MG2;
                ST_MG2:  w_next_state = ST_MY;
                ST_MY:   w_next_state = w_walk_latched ? ST_WALK : ST_SG;
                ST_WALK: w_next_state = ST_SG;
                ST_SG:   w_next_state = sensor ? ST_SGX : ST_SY;
                ST_SGX:  w_next_state = ST_SY;
                ST_SY:   w_next_state = ST_MG1;
                default: w_next_state = ST_MG1;
            endcase
        end
    end

    always_comb begin
        w_value = dur_code(T_BASE);
        w_main  = LAMP_RED;
        w_side  = LAMP_RED;
        w_walk  = 1'b0;
        case (w_next_state)
            ST_MG1, ST_MG2: w_main = LAMP_GRN;
            ST_MY: begin
                w_value = dur_code(T_YEL);
                w_main  = LAMP_YEL;
            end
            ST_WALK: begin
                w_value = dur_code(T_WALK);
                w_walk  = 1'b1;
            end
            ST_SG: w_side = LAMP_GRN;
            ST_SGX: begin
                w_value = dur_code(T_EXT);
                w_side  = LAMP_GRN;
            end
            ST_SY: begin
                w_value = dur_code(T_YEL);
                w_side  = LAMP_YEL;
            end
            default: ;
        endcase
    end

    assign w_load       = r_pend | w_qual;
    assign w_enter_walk = w_qual & (w_next_state == ST_WALK);

    request_latch u_walk_latch (
        .clock   (clock),
        .reset_n (reset_n),
        .i_set   (walk_request),
        .i_clr   (w_enter_walk),
        .o_flag  (w_walk_latched)
    );

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_MG1;
            r_start     <= 1'b0;
            r_start_d   <= 1'b0;
            r_pend      <= 1'b1;
            r_value     <= dur_code(T_BASE);
            r_main      <= LAMP_GRN;
            r_side      <= LAMP_RED;
            r_walk_lamp <= 1'b0;
        end else begin
            r_start_d <= r_start;
            r_start   <= w_load;
            r_pend    <= 1'b0;
            if (w_load) begin
                r_state     <= w_next_state;
                r_value     <= w_value;
                r_main      <= w_main;
                r_side      <= w_side;
                r_walk_lamp <= w_walk;
            end
        end
    end

    assign value       = r_value;
    assign start_timer = r_start;
    assign main_light  = r_main;
    assign side_light  = r_side;
    assign walk_lamp   = r_walk_lamp;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench: behavioural timer, phase-table reference model compared
// every cycle, plus directed scenarios with hand-computed pulse sequences.
module tb_traffic_light_controller;

    localparam int T_BASE = 6;
    localparam int T_EXT  = 3;
    localparam int T_YEL  = 2;
    localparam int T_WALK = 3;

    localparam int P_MG1 = 0, P_MG2 = 1, P_MY = 2, P_WALK = 3, P_SG = 4, P_SGX = 5, P_SY = 6;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       expired;
    logic       sensor = 1'b0;
    logic       walk_request = 1'b0;
    logic [3:0] value;
    logic       start_timer;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    traffic_light_controller #(
        .T_BASE (T_BASE),
        .T_EXT  (T_EXT),
        .T_YEL  (T_YEL),
        .T_WALK (T_WALK)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .expired      (expired),
        .sensor       (sensor),
        .walk_request (walk_request),
        .value        (value),
        .start_timer  (start_timer),
        .main_light   (main_light),
        .side_light   (side_light),
        .walk_lamp    (walk_lamp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Interval timer: expired rises 'value' ticks after it samples start_timer.
    logic force_exp = 1'b0;
    logic t_exp;
    int   t_cnt;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            t_exp <= 1'b0;
            t_cnt <= 0;
        end else if (start_timer) begin
            t_cnt <= int'(value);
            t_exp <= 1'b0;
        end else if (t_cnt > 1) begin
            t_cnt <= t_cnt - 1;
        end else if (t_cnt == 1) begin
            t_cnt <= 0;
            t_exp <= 1'b1;
        end
    end

    assign expired = force_exp | t_exp;

    // Reference model: phase table plus the age of the current phase in cycles
    // (age -1 = just out of reset, nothing loaded yet; age 0 = entry cycle).
    int         m_dur  [7] = '{T_BASE, T_BASE, T_YEL, T_WALK, T_BASE, T_EXT, T_YEL};
    logic [2:0] m_main [7] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] m_side [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
    logic       m_wlk  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    int   m_phase;
    int   m_age;
    logic m_latch;
    logic m_enter_walk;

    function automatic int next_phase(input int p, input logic sens, input logic wl);
        case (p)
            P_MG1:   return sens ? P_MY : P_MG2;
            P_MG2:   return P_MY;
            P_MY:    return wl ? P_WALK : P_SG;
            P_WALK:  return P_SG;
            P_SG:    return sens ? P_SGX : P_SY;
            P_SGX:   return P_SY;
            default: return P_MG1;
        endcase
    endfunction

    assign m_enter_walk = (m_age >= 2) && expired && (next_phase(m_phase, sensor, m_latch) == P_WALK);

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_phase <= P_MG1;
            m_age   <= -1;
            m_latch <= 1'b0;
        end else begin
            if (m_age < 0) begin
                m_age <= 0;
            end else if (expired && m_age >= 2) begin
                m_phase <= next_phase(m_phase, sensor, m_latch);
                m_age   <= 0;
            end else if (m_age < 1000) begin
                m_age <= m_age + 1;
            end
            m_latch <= walk_request | (m_latch & ~m_enter_walk);
        end
    end

    always @(negedge clock) begin
        check("cmp_start", start_timer, m_age == 0);
        check("cmp_value", value, 4'(m_dur[m_phase]));
        check("cmp_main", main_light, m_main[m_phase]);
        check("cmp_side", side_light, m_side[m_phase]);
        check("cmp_walk", walk_lamp, m_wlk[m_phase]);
        check("inv_lamps", $onehot(main_light) && $onehot(side_light)
              && (main_light == 3'b100 || side_light == 3'b100), 1'b1);
    end

    // Snapshot of the outputs at every start_timer pulse.
    typedef struct {
        logic [3:0] v;
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        int         c;
    } pulse_t;

    pulse_t pulses[$];
    int     exp_q[$];

    always @(negedge clock) begin
        if (reset_n && start_timer)
            pulses.push_back('{value, main_light, side_light, walk_lamp, cyc});
    end

    task automatic do_reset(input logic sens, input logic fexp);
        @(negedge clock);
        #2 reset_n = 1'b0;
        walk_request = 1'b0;
        sensor = sens;
        force_exp = fexp;
        repeat (2) @(negedge clock);
        pulses.delete();
    endtask

    task automatic release_reset();
        #2 reset_n = 1'b1;
    endtask

    task automatic wait_pulses(input string name, input int n, input int budget);
        for (int i = 0; i < budget && pulses.size() < n; i++) @(negedge clock);
        check({name, "_count"}, pulses.size() >= n, 1'b1);
    endtask

    task automatic check_seq(input string name);
        for (int i = 0; i < exp_q.size() && i < pulses.size(); i++)
            check($sformatf("%s_value[%0d]", name, i), pulses[i].v, exp_q[i]);
    endtask

    initial begin
        logic hit;

        // Basic round, no demand.
        do_reset(1'b0, 1'b0);
        check("rst_main", main_light, 3'b001);
        check("rst_side", side_light, 3'b100);
        check("rst_walk", walk_lamp, 1'b0);
        check("rst_start", start_timer, 1'b0);
        check("rst_value", value, 4'd6);
        release_reset();
        @(negedge clock);
        check("first_start", start_timer, 1'b1);
        check("first_value", value, 4'd6);
        check("first_main", main_light, 3'b001);
        wait_pulses("basic", 6, 300);
        exp_q = '{6, 6, 2, 6, 2, 6};
        check_seq("basic");
        if (pulses.size() >= 5) begin
            check("basic_my_main", pulses[2].m, 3'b010);
            check("basic_sg_side", pulses[3].s, 3'b001);
            check("basic_sg_main", pulses[3].m, 3'b100);
            check("basic_sy_side", pulses[4].s, 3'b010);
        end

        // Sensor held: main green cut short, side green extended.
        do_reset(1'b1, 1'b0);
        release_reset();
        wait_pulses("sensor", 6, 300);
        exp_q = '{6, 2, 6, 3, 2, 6};
        check_seq("sensor");

        // Walk request pulsed once during MG2.
        do_reset(1'b0, 1'b0);
        release_reset();
        wait_pulses("walk_arm", 2, 200);
        @(negedge clock);
        walk_request = 1'b1;
        @(negedge clock);
        walk_request = 1'b0;
        wait_pulses("walk", 10, 500);
        exp_q = '{6, 6, 2, 3, 6, 2, 6, 6, 2, 6};
        check_seq("walk");
        if (pulses.size() >= 4) begin
            check("walk_lamp_on", pulses[3].w, 1'b1);
            check("walk_main_red", pulses[3].m, 3'b100);
            check("walk_side_red", pulses[3].s, 3'b100);
        end

        // Request coinciding with the edge that enters WALK is kept.
        do_reset(1'b0, 1'b0);
        release_reset();
        @(negedge clock);
        walk_request = 1'b1;
        @(negedge clock);
        walk_request = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 600 && pulses.size() < 11; i++) begin
            if (!hit && m_enter_walk) begin
                walk_request = 1'b1;
                hit = 1'b1;
            end else begin
                walk_request = 1'b0;
            end
            @(negedge clock);
        end
        walk_request = 1'b0;
        check("walk_entry_hit", hit, 1'b1);
        check("rewalk_count", pulses.size() >= 11, 1'b1);
        exp_q = '{6, 6, 2, 3, 6, 2, 6, 6, 2, 3, 6};
        check_seq("rewalk");

        // Expired stuck high: one transition every 3 cycles.
        do_reset(1'b0, 1'b1);
        release_reset();
        wait_pulses("stuck", 9, 100);
        for (int i = 0; i + 1 < pulses.size() && i < 8; i++)
            check($sformatf("stuck_gap[%0d]", i), pulses[i + 1].c - pulses[i].c, 3);
        exp_q = '{6, 6, 2, 6, 2, 6, 6, 2, 6};
        check_seq("stuck");
        force_exp = 1'b0;

        // Reset during SGX drops the pending walk request.
        do_reset(1'b1, 1'b0);
        release_reset();
        wait_pulses("sgx", 4, 200);
        @(negedge clock);
        walk_request = 1'b1;
        @(negedge clock);
        walk_request = 1'b0;
        check("sgx_value", value, 4'd3);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_main", main_light, 3'b001);
        check("midrst_side", side_light, 3'b100);
        check("midrst_walk", walk_lamp, 1'b0);
        check("midrst_start", start_timer, 1'b0);
        sensor = 1'b0;
        pulses.delete();
        @(negedge clock);
        release_reset();
        @(negedge clock);
        check("midrst_restart", start_timer, 1'b1);
        check("midrst_value", value, 4'd6);
        wait_pulses("after_rst", 4, 200);
        exp_q = '{6, 6, 2, 6};
        check_seq("after_rst");

        // Randomised traffic, requests, stuck-expired stretches and resets.
        do_reset(1'b0, 1'b0);
        release_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            sensor = 1'($urandom_range(0, 1));
            walk_request = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) force_exp = ~force_exp;
            if ($urandom_range(0, 999) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clock);
                #2 reset_n = 1'b1;
            end
        end
        force_exp = 1'b0;
        walk_request = 1'b0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
